right_bshifter_pipe: RTL and testbench
======================================

# right_bshifter_pipe

Two-stage pipelined right barrel shifter for the EX unit. It provides logical, arithmetic and rotate right shifts with a valid/ready handshake and a result tag. It is the right-shift counterpart of the EX left shifter and sits beside it in the ALU shift path, returning results to the writeback arbiter. Shift-amount decoding is split across two register stages to close timing at 32/64-bit widths.

## Interface
- `DATA_WIDTH`, default 32: operand width.
- `SHAMT_WIDTH`, default `$clog2(DATA_WIDTH)`, with a minimum of 1: shift-amount width.
- `TAG_WIDTH`, default 5: destination-register tag, carried through unchanged.
- `SPLIT`, default `SHAMT_WIDTH/2`: number of shift-amount bits resolved in stage 1; the remaining bits are resolved in stage 2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: input operand valid.
- `in_ready` out 1: block can accept the input this cycle.
- `in_data` in DATA_WIDTH: operand.
- `in_shamt` in SHAMT_WIDTH: shift amount.
- `in_op` in 2: operation select; 00 logical right, 01 arithmetic right, 10 rotate right, 11 treated as 00.
- `in_tag` in TAG_WIDTH: result tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out DATA_WIDTH: shifted result.
- `out_tag` out TAG_WIDTH: tag of the result.

## Operation
- Stage 1 (S1):
  - Applies the shifts for `in_shamt[SPLIT-1:0]`, one conditional shift by 2^i per bit.
  - Registers the partial result, the upper shamt bits, op, tag and the sign bit `in_data[DATA_WIDTH-1]`.
- Stage 2 (S2):
  - Applies the shifts for the remaining shamt bits to the S1 register.
  - Registers the result into the output register.
- Fill rules:
  - Logical: vacated MSBs are 0.
  - Arithmetic: vacated MSBs take the sign captured in S1. Sign is taken from the original operand and is never re-read from the partial result.
  - Rotate: bits shifted out at the LSB re-enter at the MSB.
- Shift amount 0 returns `in_data` unchanged for every op.
- Shift amounts ≥ DATA_WIDTH cannot occur, because shamt is SHAMT_WIDTH bits. If DATA_WIDTH is not a power of two, amounts ≥ DATA_WIDTH give all-fill for logical/arithmetic and amount mod DATA_WIDTH for rotate.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - `in_valid` and payload are not required to stay stable when not accepted; the block samples only on transfer.
  - `out_valid`/`out_data`/`out_tag` stay stable while `out_valid && !out_ready`.
- Stall propagation:
  - `s2_advance = !out_valid || out_ready`.
  - `s1_advance = !s1_valid || s2_advance`.
  - `in_ready = s1_advance`, a combinational path from `out_ready`. No skid buffer.
- Flush:
  - On a `flush`-high edge, S1 and output valids clear to 0. Data registers may keep stale values.
  - An input presented in the flush cycle is dropped, and `in_ready` is still reported.
- Simultaneous S2 output accept, S1→S2 move and new input: all three occur in the same cycle, with no bubble.

## Timing
- Latency is 2 cycles from input transfer to `out_valid`, with no stall. Throughput is 1 result/cycle.
- Reset (asynchronous assert; deassert synchronized externally):
  - `out_valid`=0, `out_data`=0, `out_tag`=0.
  - S1 valid=0 and S1 data=0.
  - `in_ready`=1 after reset.
- Reset asserted mid-operation discards all in-flight results immediately; no partial output appears.
- `flush` and `rst` together: `rst` dominates.
- The worst-case combinational depth per stage is ceil(SHAMT_WIDTH/2) mux levels.

## Structure
- Shared package `ex_pkg`:
  - Op encodings: `SHR_LOGIC`=2'b00, `SHR_ARITH`=2'b01, `SHR_ROT`=2'b10.
  - A shared shift-op typedef, also used by the left shifter decode.
- One combinational sub-module, `rshift_stage_slice`:
  - Parameters DATA_WIDTH, LO_BIT, HI_BIT.
  - Inputs data, shamt slice, op, sign; output shifted data.
  - Instantiated once per pipeline stage.
- Top level holds only the valid/ready control, the S1/S2 registers and the flush/reset logic.

## Test plan
- Logical: `in_data`=0x8000_00F0, shamt=4, op=00 → after 2 cycles `out_data`=0x0800_000F, `out_tag` matches the input tag.
- Arithmetic: 0x8000_00F0, shamt=31, op=01 → 0xFFFF_FFFF. With 0x7FFF_FFFF, shamt=31 → 0x0000_0000.
- Rotate: 0x0000_0001, shamt=1, op=10 → 0x8000_0000. With 0x1234_5678, shamt=0, any op → 0x1234_5678. Op=11 behaves as logical.
- Back-to-back and stall:
  - Stream 4 inputs with tags 1–4 with `out_ready`=1 → outputs on consecutive cycles starting at cycle 2.
  - Hold `out_ready`=0 for 3 cycles mid-stream → `in_ready` drops once S1 and S2 are full, the output holds stable, no loss or duplication, and tag order is preserved.
- Flush: issue tags 7 and 8, assert `flush` one cycle after tag 8 is accepted → neither tag emerges, and the next input emerges 2 cycles after its transfer.
- Reset mid-stream: assert `rst` asynchronously between edges with 2 items in flight → `out_valid` goes 0 immediately and no result appears after deassert. Also run a random sweep of all ops and shamts against a reference model at DATA_WIDTH=32 and 64.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shift op encodings and decode shared by the EX left/right shifters
package ex_pkg;

  localparam int SHIFT_OP_WIDTH = 2;

  typedef enum logic [SHIFT_OP_WIDTH-1:0] {
    SHR_LOGIC = 2'b00,
    SHR_ARITH = 2'b01,
    SHR_ROT   = 2'b10,
    SHR_RSVD  = 2'b11
  } shift_op_e;

  // The reserved encoding collapses to logical so downstream stages see only three ops.
  function automatic shift_op_e shr_op_decode(input logic [SHIFT_OP_WIDTH-1:0] raw);
    case (raw)
      2'b01:   return SHR_ARITH;
      2'b10:   return SHR_ROT;
      default: return SHR_LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/rshift_stage_slice.sv
// rtl/rshift_stage_slice.sv - conditional right shifts for shamt bits LO_BIT..HI_BIT
module rshift_stage_slice
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LO_BIT = 0,
  parameter int HI_BIT = 0,
  localparam int NBITS = (HI_BIT >= LO_BIT) ? (HI_BIT - LO_BIT + 1) : 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [NBITS-1:0]      shamt,
  input  shift_op_e             op,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int NUSED = (HI_BIT >= LO_BIT) ? (HI_BIT - LO_BIT + 1) : 0;

  logic [NBITS-1:0] sh_rem;

  // Fill comes from the captured sign, never from the partially shifted value.
  function automatic logic [DATA_WIDTH-1:0] shr_by(
    input logic [DATA_WIDTH-1:0] v,
    input int                    amt,
    input shift_op_e             op_i,
    input logic                  sgn
  );
    int                    rot;
    logic [DATA_WIDTH-1:0] fill;
    rot  = amt % DATA_WIDTH;
    fill = ~({DATA_WIDTH{1'b1}} >> amt);
    case (op_i)
      SHR_ARITH: shr_by = (v >> amt) | (sgn ? fill : '0);
      SHR_ROT:   shr_by = (v >> rot) | (v << (DATA_WIDTH - rot));
      default:   shr_by = v >> amt;
    endcase
  endfunction

  always_comb begin
    data_out = data;
    sh_rem   = shamt;
    for (int i = 0; i < NUSED; i++) begin
      if (sh_rem[0]) begin
        data_out = shr_by(data_out, 1 << (LO_BIT + i), op, sign);
      end
      sh_rem = sh_rem >> 1;
    end
  end

endmodule

// File: rtl/right_bshifter_pipe.sv
// rtl/right_bshifter_pipe.sv - two-stage pipelined right barrel shifter with valid/ready and tag
module right_bshifter_pipe
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
  parameter int TAG_WIDTH   = 5,
  parameter int SPLIT       = SHAMT_WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [1:0]             in_op,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int HI_W = SHAMT_WIDTH - SPLIT;
  localparam int LO_W = (SPLIT > 0) ? SPLIT : 1;

  logic [LO_W-1:0]       shamt_lo;
  logic [HI_W-1:0]       shamt_hi;
  shift_op_e             in_op_dec;
  logic [DATA_WIDTH-1:0] s1_result;
  logic [DATA_WIDTH-1:0] s2_result;

  logic                  s1_valid_q,    s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,     s1_data_d;
  logic [HI_W-1:0]       s1_shamt_hi_q, s1_shamt_hi_d;
  shift_op_e             s1_op_q,       s1_op_d;
  logic                  s1_sign_q,     s1_sign_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q,      s1_tag_d;
  logic                  out_valid_q,   out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q,     out_tag_d;

  logic s1_advance;
  logic s2_advance;

  generate
    if (SPLIT > 0) begin : g_lo
      assign shamt_lo = in_shamt[LO_W-1:0];
    end else begin : g_no_lo
      assign shamt_lo = 1'b0;
    end
  endgenerate

  assign shamt_hi  = in_shamt[SHAMT_WIDTH-1:SPLIT];
  assign in_op_dec = shr_op_decode(in_op);

  rshift_stage_slice #(
    .DATA_WIDTH(DATA_WIDTH),
    .LO_BIT    (0),
    .HI_BIT    (SPLIT - 1)
  ) u_s1_slice (
    .data    (in_data),
    .shamt   (shamt_lo),
    .op      (in_op_dec),
    .sign    (in_data[DATA_WIDTH-1]),
    .data_out(s1_result)
  );

  rshift_stage_slice #(
    .DATA_WIDTH(DATA_WIDTH),
    .LO_BIT    (SPLIT),
    .HI_BIT    (SHAMT_WIDTH - 1)
  ) u_s2_slice (
    .data    (s1_data_q),
    .shamt   (s1_shamt_hi_q),
    .op      (s1_op_q),
    .sign    (s1_sign_q),
    .data_out(s2_result)
  );

  // No skid buffer: in_ready is combinational back through both stages from out_ready.
  assign s2_advance = !out_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = s1_advance;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s1_shamt_hi_d = s1_shamt_hi_q;
    s1_op_d       = s1_op_q;
    s1_sign_d     = s1_sign_q;
    s1_tag_d      = s1_tag_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_tag_d     = out_tag_q;

    if (s1_advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d     = s1_result;
        s1_shamt_hi_d = shamt_hi;
        s1_op_d       = in_op_dec;
        s1_sign_d     = in_data[DATA_WIDTH-1];
        s1_tag_d      = in_tag;
      end
    end

    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s2_result;
        out_tag_d  = s1_tag_q;
      end
    end

    // Flush kills only the valids; stale payload is harmless behind a cleared valid.
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_shamt_hi_q <= '0;
      s1_op_q       <= SHR_LOGIC;
      s1_sign_q     <= 1'b0;
      s1_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_shamt_hi_q <= s1_shamt_hi_d;
      s1_op_q       <= s1_op_d;
      s1_sign_q     <= s1_sign_d;
      s1_tag_q      <= s1_tag_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_right_bshifter_pipe.sv
// tb/tb_right_bshifter_pipe.sv - scoreboard bench for right_bshifter_pipe at 32 and 64 bits
module tb_right_bshifter_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic [31:0] in_data32;
  logic [4:0]  in_shamt32;
  logic [63:0] in_data64;
  logic [5:0]  in_shamt64;
  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  logic [4:0]  out_tag32, out_tag64;

  typedef struct {
    logic [31:0] d32;
    logic [63:0] d64;
    logic [4:0]  tag;
    int          exp_cyc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  bit          no_stall = 1;
  bit          sweep_done = 0;
  logic [31:0] rd;
  logic [1:0]  rop;
  logic [63:0] tmp64;

  right_bshifter_pipe #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data32),
    .in_shamt(in_shamt32), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32), .out_tag(out_tag32)
  );

  right_bshifter_pipe #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
    .in_shamt(in_shamt64), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end

  // Bit-by-bit reference: result bit j comes from operand bit j+sh.
  function automatic logic [63:0] ref_shr(input logic [63:0] d, input int w, input int sh,
                                          input logic [1:0] op);
    logic [63:0] r;
    int          s;
    r = '0;
    for (int j = 0; j < w; j++) begin
      s = j + sh;
      case (op)
        2'b01:   r[j] = (s < w) ? d[s] : d[w-1];
        2'b10:   r[j] = d[s % w];
        default: r[j] = (s < w) ? d[s] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [4:0] tag, input logic [31:0] exp32);
    logic [63:0] d64;
    logic [5:0]  sh64;
    bit          took;
    exp_t        e;
    d64        = {$urandom, $urandom};
    sh64       = 6'($urandom_range(0, 63));
    in_valid   = 1'b1;
    in_data32  = d;
    in_shamt32 = sh;
    in_op      = op;
    in_tag     = tag;
    in_data64  = d64;
    in_shamt64 = sh64;
    took       = 0;
    for (int k = 0; k < 32 && !took; k++) begin
      @(negedge clk);
      if (in_ready32 && !flush) begin
        e.d32     = exp32;
        e.d64     = ref_shr(d64, 64, int'(sh64), op);
        e.tag     = tag;
        e.exp_cyc = cyc + 2;
        e.lat     = no_stall;
        sbq.push_back(e);
        took = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!took) check("send_accept", 64'(in_ready32), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 64 && sbq.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_out", 64'(out_valid32), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("data32", 64'(out_data32), 64'(mon_e.d32));
        check("tag32", 64'(out_tag32), 64'(mon_e.tag));
        check("valid64", 64'(out_valid64), 64'd1);
        check("data64", out_data64, mon_e.d64);
        check("tag64", 64'(out_tag64), 64'(mon_e.tag));
        if (mon_e.lat) check("latency", 64'(cyc), 64'(mon_e.exp_cyc));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_tag = '0; in_data32 = '0; in_shamt32 = '0; in_data64 = '0; in_shamt64 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_out_data", 64'(out_data32), 64'd0);
    check("rst_out_tag", 64'(out_tag32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(32'h8000_00F0, 5'd4, 2'b00, 5'd3, 32'h0800_000F);
    @(negedge clk);
    check("lat_not_early", 64'(out_valid32), 64'd0);
    wait_drain();

    send(32'h8000_00F0, 5'd31, 2'b01, 5'd4, 32'hFFFF_FFFF);
    send(32'h7FFF_FFFF, 5'd31, 2'b01, 5'd5, 32'h0000_0000);
    send(32'h8000_00F0, 5'd4,  2'b01, 5'd6, 32'hF800_000F);
    send(32'h0000_0001, 5'd1,  2'b10, 5'd9, 32'h8000_0000);
    send(32'h0000_0001, 5'd31, 2'b10, 5'd10, 32'h0000_0002);
    send(32'h1234_5678, 5'd8,  2'b10, 5'd11, 32'h7812_3456);
    send(32'h8000_0000, 5'd31, 2'b00, 5'd12, 32'h0000_0001);
    send(32'h1234_5678, 5'd0,  2'b00, 5'd13, 32'h1234_5678);
    send(32'h1234_5678, 5'd0,  2'b01, 5'd14, 32'h1234_5678);
    send(32'h1234_5678, 5'd0,  2'b10, 5'd15, 32'h1234_5678);
    send(32'h1234_5678, 5'd0,  2'b11, 5'd16, 32'h1234_5678);
    send(32'h8000_00F0, 5'd4,  2'b11, 5'd17, 32'h0800_000F);
    for (int t = 1; t <= 4; t++) begin
      rd  = $urandom;
      rop = 2'($urandom_range(0, 3));
      tmp64 = ref_shr({32'h0, rd}, 32, t * 7, rop);
      send(rd, 5'(t * 7), rop, 5'(t), tmp64[31:0]);
    end
    wait_drain();

    no_stall = 0;
    send(32'hA5A5_0000, 5'd16, 2'b00, 5'd10, 32'h0000_A5A5);
    send(32'hF000_0000, 5'd4,  2'b01, 5'd11, 32'hFF00_0000);
    out_ready = 1'b0;
    fork
      send(32'h0000_00FF, 5'd4, 2'b10, 5'd12, 32'hF000_000F);
      begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready32), 64'd0);
          check("stall_in_ready64", 64'(in_ready64), 64'd0);
          check("stall_out_valid", 64'(out_valid32), 64'd1);
          check("stall_out_tag", 64'(out_tag32), 64'd10);
          check("stall_out_data", 64'(out_data32), 64'h0000_A5A5);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    send(32'h0000_0100, 5'd8, 2'b00, 5'd13, 32'h0000_0001);
    wait_drain();

    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 5'd4, 2'b00, 5'd7, 32'h0DEA_DBEE);
    send(32'hCAFE_F00D, 5'd8, 2'b01, 5'd8, 32'hFFCA_FEF0);
    flush = 1'b1; in_valid = 1'b1; in_data32 = 32'h1111_1111; in_tag = 5'd21;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sbq.delete();
    check("flush_out_valid", 64'(out_valid32), 64'd0);
    check("flush_out_valid64", 64'(out_valid64), 64'd0);
    check("flush_in_ready", 64'(in_ready32), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("flush_quiet", 64'(out_valid32), 64'd0);
    end
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_data32 = 32'h2222_2222; in_tag = 5'd22;
    @(negedge clk);
    check("flush_cycle_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("flush_drop_quiet", 64'(out_valid32), 64'd0);
    end
    no_stall = 1;
    @(posedge clk);
    #1;
    send(32'h0F0F_0F0F, 5'd4, 2'b10, 5'd20, 32'hF0F0_F0F0);
    wait_drain();

    send(32'h8765_4321, 5'd12, 2'b01, 5'd25, 32'hFFF8_7654);
    send(32'h8765_4321, 5'd12, 2'b00, 5'd26, 32'h0008_7654);
    #2 rst = 1'b1;
    sbq.delete();
    #1;
    check("rst_mid_out_valid", 64'(out_valid32), 64'd0);
    check("rst_mid_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_mid_out_data", 64'(out_data32), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_quiet", 64'(out_valid32), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'h0000_8000, 5'd15, 2'b00, 5'd27, 32'h0000_0001);
    wait_drain();

    no_stall = 0;
    sweep_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rd  = $urandom;
          rop = 2'($urandom_range(0, 3));
          tmp64 = ref_shr({32'h0, rd}, 32, i % 32, rop);
          send(rd, 5'(i % 32), rop, 5'(i), tmp64[31:0]);
        end
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
